// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// master drives wr/data_in/rd/err_clr; slave returns data and status.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              wr;
  logic [DATA_W-1:0] data_in;
  logic              rd;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_almost_full;
  logic              fifo_almost_empty;
  logic [ADDR_W:0]   fifo_count;
  logic              fifo_overflow;
  logic              fifo_underflow;

  modport master (
    output wr,
    output data_in,
    output rd,
    output err_clr,
    input  data_out,
    input  fifo_full,
    input  fifo_empty,
    input  fifo_almost_full,
    input  fifo_almost_empty,
    input  fifo_count,
    input  fifo_overflow,
    input  fifo_underflow
  );

  modport slave (
    input  wr,
    input  data_in,
    input  rd,
    input  err_clr,
    output data_out,
    output fifo_full,
    output fifo_empty,
    output fifo_almost_full,
    output fifo_almost_empty,
    output fifo_count,
    output fifo_overflow,
    output fifo_underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO, 2**ADDR_W deep, with level flags and sticky errors.
// Ports: clk, rst_n (async, active low), bus (sync_fifo_param_if.slave).
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sync_fifo_param_if.slave     bus
);

  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W:0] FULL_C = PW'(DEPTH);
  localparam logic [ADDR_W:0] AF_C   = PW'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C   = PW'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];

  // Extra MSB on each pointer is the wrap bit, so full
  // and empty are told apart by the pointer difference.
  logic [ADDR_W:0] wptr;
  logic [ADDR_W:0] rptr;
  logic [ADDR_W:0] count;

  logic full;
  logic empty;
  logic we_ok;
  logic rd_ok;

  logic ovf;
  logic unf;

  assign count = wptr - rptr;
  assign full  = (count == FULL_C);
  assign empty = (count == '0);

  // Both decisions use the pre-edge flags, so wr&rd on a
  // full FIFO only reads and on an empty one only writes.
  assign we_ok = bus.wr & ~full;
  assign rd_ok = bus.rd & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
    end else if (we_ok) begin
      wptr <= wptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= '0;
    end else if (rd_ok) begin
      rptr <= rptr + 1'b1;
    end
  end

  // Storage is left unreset; clearing the pointers is
  // enough to discard its contents.
  always_ff @(posedge clk) begin
    if (we_ok) begin
      mem[wptr[ADDR_W-1:0]] <= bus.data_in;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented directly; rd just pops it.
  assign bus.data_out = mem[rptr[ADDR_W-1:0]];
`else
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (rd_ok) begin
      dout_q <= mem[rptr[ADDR_W-1:0]];
    end
  end

  assign bus.data_out = dout_q;
`endif

  // A new error in the same cycle outranks err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (bus.wr & full) begin
      ovf <= 1'b1;
    end else if (bus.err_clr) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unf <= 1'b0;
    end else if (bus.rd & empty) begin
      unf <= 1'b1;
    end else if (bus.err_clr) begin
      unf <= 1'b0;
    end
  end

  assign bus.fifo_count        = count;
  assign bus.fifo_full         = full;
  assign bus.fifo_empty        = empty;
  assign bus.fifo_almost_full  = (count >= AF_C);
  assign bus.fifo_almost_empty = (count <= AE_C);
  assign bus.fifo_overflow     = ovf;
  assign bus.fifo_underflow    = unf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised self-checking bench for sync_fifo_param.
// Reference model is a queue plus sticky flag bits.
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  localparam int AE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  sync_fifo_param #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit m_ovf = 0;
  bit m_unf = 0;

`ifdef SYNC_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  function automatic logic [DW-1:0] exp_dout();
    if (FWFT) return q[0];
    return m_dout;
  endfunction

  function automatic bit dout_known();
    return !FWFT || q.size() != 0;
  endfunction

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  // Drive one cycle, advance the model on the edge,
  // return 1 ns after the edge for sampling.
  task automatic step(input bit w, input logic [DW-1:0] d,
                      input bit r, input bit c);
    bit pfull;
    bit pempty;
    bus.wr = w;
    bus.data_in = d;
    bus.rd = r;
    bus.err_clr = c;
    @(posedge clk);
    pfull = (q.size() == DEPTH);
    pempty = (q.size() == 0);
    if (r && !pempty) m_dout = q.pop_front();
    if (w && !pfull) q.push_back(d);
    if (w && pfull) m_ovf = 1;
    else if (c) m_ovf = 0;
    if (r && pempty) m_unf = 1;
    else if (c) m_unf = 0;
    #1;
    bus.wr = 0;
    bus.rd = 0;
    bus.err_clr = 0;
  endtask

  task automatic test_reset();
    bus.wr = 0;
    bus.rd = 0;
    bus.err_clr = 0;
    bus.data_in = '0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (bus.fifo_count !== 5'd0 || bus.fifo_empty !== 1'b1 ||
        bus.fifo_full !== 1'b0 || bus.fifo_almost_empty !== 1'b1 ||
        bus.fifo_almost_full !== 1'b0 || bus.fifo_overflow !== 1'b0 ||
        bus.fifo_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: cnt=%0d e=%b f=%b ae=%b af=%b o=%b u=%b want 0 1 0 1 0 0 0",
               bus.fifo_count, bus.fifo_empty, bus.fifo_full,
               bus.fifo_almost_empty, bus.fifo_almost_full,
               bus.fifo_overflow, bus.fifo_underflow);
    end
    if (!FWFT) begin
      n_chk++;
      if (bus.data_out !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_dout: got %h want 00", bus.data_out);
      end
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, DW'(i), 0, 0);
      n_chk++;
      if (bus.fifo_count !== 5'(i) ||
          bus.fifo_almost_full !== (i >= AF) ||
          bus.fifo_almost_empty !== (i <= AE) ||
          bus.fifo_overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_%0d: cnt=%0d af=%b ae=%b o=%b want %0d %b %b 0",
                 i, bus.fifo_count, bus.fifo_almost_full,
                 bus.fifo_almost_empty, bus.fifo_overflow,
                 i, i >= AF, i <= AE);
      end
      if (FWFT) begin
        n_chk++;
        if (bus.data_out !== 8'h01) begin
          n_fail++;
          $display("FAIL fill_fwft_head: got %h want 01", bus.data_out);
        end
      end
    end
    n_chk++;
    if (bus.fifo_full !== 1'b1 || bus.fifo_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: full=%b empty=%b want 1 0",
               bus.fifo_full, bus.fifo_empty);
    end
  endtask

  task automatic test_overflow_drain();
    step(1, 8'hAA, 0, 0);
    n_chk++;
    if (bus.fifo_overflow !== 1'b1 || bus.fifo_count !== 5'd16) begin
      n_fail++;
      $display("FAIL ovf_set: o=%b cnt=%0d want 1 16",
               bus.fifo_overflow, bus.fifo_count);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      if (FWFT) begin
        n_chk++;
        if (bus.data_out !== DW'(i)) begin
          n_fail++;
          $display("FAIL drain_fwft_%0d: got %h want %h",
                   i, bus.data_out, DW'(i));
        end
      end
      step(0, '0, 1, 0);
      if (!FWFT) begin
        n_chk++;
        if (bus.data_out !== DW'(i)) begin
          n_fail++;
          $display("FAIL drain_%0d: got %h want %h",
                   i, bus.data_out, DW'(i));
        end
      end
      n_chk++;
      if (bus.fifo_count !== 5'(DEPTH - i)) begin
        n_fail++;
        $display("FAIL drain_cnt_%0d: got %0d want %0d",
                 i, bus.fifo_count, DEPTH - i);
      end
    end
    n_chk++;
    if (bus.fifo_empty !== 1'b1 || bus.fifo_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_end: empty=%b o=%b want 1 1",
               bus.fifo_empty, bus.fifo_overflow);
    end
    step(0, '0, 0, 1);
  endtask

  task automatic test_underflow();
    logic [DW-1:0] held;
    held = bus.data_out;
    step(0, '0, 1, 0);
    n_chk++;
    if (bus.fifo_underflow !== 1'b1 || bus.fifo_count !== 5'd0 ||
        (!FWFT && bus.data_out !== held)) begin
      n_fail++;
      $display("FAIL unf_set: u=%b cnt=%0d dout=%h want 1 0 %h",
               bus.fifo_underflow, bus.fifo_count,
               bus.data_out, held);
    end
    step(0, '0, 0, 1);
    n_chk++;
    if (bus.fifo_underflow !== 1'b0 || bus.fifo_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL unf_clr: u=%b o=%b want 0 0",
               bus.fifo_underflow, bus.fifo_overflow);
    end
    step(0, '0, 1, 1);
    n_chk++;
    if (bus.fifo_underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL unf_prio: got %b want 1", bus.fifo_underflow);
    end
    step(0, '0, 0, 1);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    d = 8'h30;
    for (int i = 0; i < 5; i++) begin
      step(1, d, 0, 0);
      d++;
    end
    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] head;
      head = q[0];
      if (FWFT) begin
        n_chk++;
        if (bus.data_out !== head) begin
          n_fail++;
          $display("FAIL b2b_fwft_%0d: got %h want %h",
                   i, bus.data_out, head);
        end
      end
      step(1, d, 1, 0);
      d++;
      n_chk++;
      if (bus.fifo_count !== 5'd5 ||
          (!FWFT && bus.data_out !== head)) begin
        n_fail++;
        $display("FAIL b2b_%0d: cnt=%0d dout=%h want 5 %h",
                 i, bus.fifo_count, bus.data_out, head);
      end
    end
    while (q.size() != 0) step(0, '0, 1, 0);
  endtask

  task automatic test_async_reset();
    step(1, 8'h51, 0, 0);
    step(1, 8'h52, 0, 0);
    step(1, 8'h53, 0, 0);
    #3;
    rst_n = 0;
    model_reset();
    #1;
    n_chk++;
    if (bus.fifo_empty !== 1'b1 || bus.fifo_count !== 5'd0 ||
        bus.fifo_full !== 1'b0 || bus.fifo_overflow !== 1'b0 ||
        (!FWFT && bus.data_out !== 8'h00)) begin
      n_fail++;
      $display("FAIL async_rst: e=%b cnt=%0d f=%b o=%b dout=%h",
               bus.fifo_empty, bus.fifo_count, bus.fifo_full,
               bus.fifo_overflow, bus.data_out);
    end
    @(negedge clk);
    rst_n = 1;
    step(1, 8'h77, 0, 0);
    n_chk++;
    if (bus.fifo_count !== 5'd1 || (FWFT && bus.data_out !== 8'h77)) begin
      n_fail++;
      $display("FAIL post_rst_wr: cnt=%0d dout=%h want 1 77",
               bus.fifo_count, bus.data_out);
    end
    step(0, '0, 1, 0);
    n_chk++;
    if (bus.fifo_empty !== 1'b1 || (!FWFT && bus.data_out !== 8'h77)) begin
      n_fail++;
      $display("FAIL post_rst_rd: e=%b dout=%h want 1 77",
               bus.fifo_empty, bus.data_out);
    end
  endtask

  // Phases bias towards writes or reads so both the
  // full and empty boundaries are hit repeatedly.
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      int wp;
      bit w;
      bit r;
      bit c;
      wp = ((i / 75) % 2 == 0) ? 75 : 25;
      w = ($urandom_range(0, 99) < wp);
      r = ($urandom_range(0, 99) < 100 - wp);
      c = ($urandom_range(0, 15) == 0);
      step(w, DW'($urandom), r, c);
      n_chk++;
      if (bus.fifo_count !== 5'(q.size()) ||
          bus.fifo_full !== (q.size() == DEPTH) ||
          bus.fifo_empty !== (q.size() == 0) ||
          bus.fifo_almost_full !== (q.size() >= AF) ||
          bus.fifo_almost_empty !== (q.size() <= AE) ||
          bus.fifo_overflow !== m_ovf ||
          bus.fifo_underflow !== m_unf) begin
        n_fail++;
        $display("FAIL rand_stat_%0d: cnt=%0d want %0d o=%b/%b u=%b/%b",
                 i, bus.fifo_count, q.size(), bus.fifo_overflow,
                 m_ovf, bus.fifo_underflow, m_unf);
      end
      if (dout_known()) begin
        n_chk++;
        if (bus.data_out !== exp_dout()) begin
          n_fail++;
          $display("FAIL rand_dout_%0d: got %h want %h",
                   i, bus.data_out, exp_dout());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits, minimum 1.
REQ-002 Parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W entries, minimum ADDR_W 2.
REQ-003 Parameter AF_LEVEL, default 12: almost-full threshold in entries, range 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 4: almost-empty threshold in entries, range 0..DEPTH-1.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 wr  in  1  write request.
REQ-008 data_in  in  DATA_W  write data, sampled on an accepted write.
REQ-009 rd  in  1  read request.
REQ-010 err_clr  in  1  synchronous clear of the sticky error flags.
REQ-011 data_out  out  DATA_W  read data.
REQ-012 fifo_full  out  1  count == DEPTH.
REQ-013 fifo_empty  out  1  count == 0.
REQ-014 fifo_almost_full  out  1  count >= AF_LEVEL.
REQ-015 fifo_almost_empty  out  1  count <= AE_LEVEL.
REQ-016 fifo_count  out  ADDR_W+1  current number of stored entries, 0..DEPTH.
REQ-017 fifo_overflow  out  1  sticky: write attempted while full.
REQ-018 fifo_underflow  out  1  sticky: read attempted while empty.

Function
REQ-019 Write and read pointers SHALL be ADDR_W+1 bits; the low ADDR_W bits address storage, the MSB is the wrap bit; both increment modulo 2**(ADDR_W+1).
REQ-020 fifo_count SHALL equal (wptr - rptr) modulo 2**(ADDR_W+1), derived combinationally from the registered pointers.
REQ-021 Accepted write (we_ok = wr & ~fifo_full) SHALL store data_in at wptr and increment wptr at the same edge.
REQ-022 Accepted read (rd_ok = rd & ~fifo_empty) SHALL increment rptr at the edge.
REQ-023 Full and empty SHALL be evaluated from pre-edge state: wr&rd while full accepts the read only; wr&rd while empty accepts the write only; wr&rd otherwise accepts both and count is unchanged.
REQ-024 Default read mode: on rd_ok, data_out SHALL load mem[rptr] at that edge (1-cycle latency) and otherwise hold its value.
REQ-025 fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty SHALL be combinational from fifo_count with no extra latency after the pointer update.
REQ-026 fifo_overflow SHALL set at an edge where wr & fifo_full, and fifo_underflow at an edge where rd & fifo_empty.
REQ-027 err_clr SHALL clear both sticky flags at the edge; a set condition in the same cycle SHALL take priority over err_clr.
REQ-028 Rejected writes and reads SHALL not modify pointers, storage or data_out.
REQ-029 Pointer wrap past DEPTH SHALL be seamless; order and data integrity SHALL hold across any number of wraps.

Reset
REQ-030 rst_n low SHALL asynchronously set wptr=0, rptr=0, data_out=0, fifo_overflow=0, fifo_underflow=0; hence fifo_empty=1, fifo_full=0, fifo_count=0, fifo_almost_empty=1, fifo_almost_full=0.
REQ-031 Storage array SHALL not be reset; reset asserted mid-operation SHALL discard all content.
REQ-032 The first edge after rst_n deasserts SHALL accept requests normally.

Configuration
REQ-033 Macro SYNC_FIFO_FWFT_EN SHALL select first-word-fall-through mode when defined.
REQ-034 With SYNC_FIFO_FWFT_EN defined: data_out SHALL combinationally equal mem[rptr] whenever fifo_empty=0 (value undefined when empty), rd acts as acknowledge, and a word written into an empty FIFO SHALL appear on data_out in the cycle after the write edge.
REQ-035 Without the macro: registered 1-cycle-latency read per REQ-024; all other requirements are identical in both modes.

Verification
REQ-036 Reset, then 16 writes of 0x01..0x10 with rd=0 -> fifo_full=1, fifo_count=16, fifo_almost_full=1 from the 12th write onward, fifo_overflow=0.
REQ-037 From full, one write of 0xAA -> fifo_overflow=1, count stays 16; next 16 reads return 0x01..0x10 in order, 0xAA never returned.
REQ-038 From empty, rd=1 for one cycle -> fifo_underflow=1, rptr unchanged; err_clr for one cycle -> flag clears; err_clr concurrent with rd on empty -> flag stays 1.
REQ-039 With count=5, wr=rd=1 for 40 cycles on incrementing data -> count holds 5, outputs strictly in order across pointer wraps.
REQ-040 Write 3 words, assert rst_n low mid-cycle -> outputs take reset values immediately, fifo_empty=1, no stale data read afterwards.
REQ-041 Run REQ-036/037 in both modes: registered data one cycle after rd_ok; FWFT data_out=0x01 one cycle after the first write.
